sha256_digest_writer: RTL and testbench
=======================================

Name: sha256_digest_writer

Overview:
Memory-write end of the SHA-256 datapath. Captures a completed digest (8 x 32-bit words, H0..H7) in one cycle, then writes the words sequentially to the output SRAM, one per cycle, at consecutive addresses. It pulses write_complete when the last word is written. It counterpart to the block-read address counter on the input side.

Parameters:
NUMBER_OF_WORDS, 8, digest words written per transfer (>=2)
DATA_WIDTH, 32, bits per word
ADDR_WIDTH, 16, output SRAM address width
BASE_ADDRESS, 0, address of word 0

Ports:
clock  input  1  clock
reset  input  1  reset, synchronous, active-high
hash_valid  input  1  one-cycle strobe: hash_in holds a finished digest
hash_in  input  NUMBER_OF_WORDS*DATA_WIDTH  digest; word 0 (H0) in the most significant DATA_WIDTH bits
busy  output  1  high while the captured digest is not fully written
write_enable  output  1  SRAM write strobe
write_address  output  ADDR_WIDTH  SRAM address
write_data  output  DATA_WIDTH  SRAM write data
write_complete  output  1  one-cycle pulse after the last word is written

Behaviour:
- All outputs are registered. On reset they are 0 on the next edge; the state goes to IDLE and the word index to 0.
- Reset mid-transfer aborts the transfer. No further writes are issued and write_complete does not pulse.
- The FSM has three states: IDLE, WRITE, DONE.
- IDLE:
  - hash_valid=1 at edge N captures hash_in into a holding register and moves to WRITE.
  - busy goes high at N+1.
- WRITE: each cycle drives write_enable=1, write_address=BASE_ADDRESS+index (truncated to ADDR_WIDTH, wraps modulo 2^ADDR_WIDTH) and write_data=word[index]. The index increments each cycle.
- Timing for a capture at edge N:
  - The first write (index 0) is visible in cycle N+1.
  - The last write (index NUMBER_OF_WORDS-1) is visible in cycle N+NUMBER_OF_WORDS. The FSM then goes to DONE.
- DONE (one cycle): write_complete=1, write_enable=0, busy=1. The next state is IDLE.
- busy is low in IDLE only. A new hash_valid is accepted from cycle N+NUMBER_OF_WORDS+2 onward.
- hash_valid while busy=1 is ignored. The captured digest is unchanged and no error is flagged.
- The index width is $clog2(NUMBER_OF_WORDS). The index is 0 in IDLE and DONE.
- When write_enable=0, write_address and write_data hold their last values.

Optional Feature:
Macro SHA_WRITER_STALL_EN.
- Defined: adds the port mem_ready (input, 1).
  - A write is accepted only in a cycle with write_enable=1 and mem_ready=1.
  - While mem_ready=0, write_enable stays 1 and the address, data and index hold.
  - DONE is entered only after the last word is accepted.
  - Reset still aborts immediately.
- Undefined: the port is absent and behaviour is as if mem_ready=1, with the fixed latency above.

Decomposition:
- Shared package sha256_pkg holds:
  - the constants WORD_WIDTH=32 and NUM_HASH_WORDS=8;
  - the writer state enum (IDLE, WRITE, DONE);
  - the function for word-index extraction from the packed digest.
- One natural sub-module: write_address_counter. It holds the index register with clear, increment-enable and last-word flag, and mirrors the read-side counter.

Test Plan:
- Reset high 3 cycles, then low -> all outputs 0; busy=0.
- hash_valid at edge N, hash_in=H0..H7=32'h6a09e667,bb67ae85,3c6ef372,a54ff53a,510e527f,9b05688c,1f83d9ab,5be0cd19, BASE_ADDRESS=0 ->
  - writes to address 0..7 with those words in cycles N+1..N+8;
  - write_complete=1 only in N+9; busy=0 at N+10.
- Second hash_valid at N+3 during a transfer -> ignored; all 8 written words still come from the first digest.
- BASE_ADDRESS=16'hFFFE -> addresses FFFE, FFFF, 0000..0005 (wrap-around).
- Reset asserted in cycle N+4 -> write_enable=0 from the next edge, no write_complete; a fresh hash_valid afterwards produces a full 8-word transfer.
- With SHA_WRITER_STALL_EN, mem_ready=0 for 3 cycles while index=2 -> address 2 and its data are held for 4 cycles; write_complete arrives 3 cycles later than unstalled (N+12).

Source files
------------

// File: rtl/sha256_pkg.sv
// sha256_pkg
// Shared definitions for the SHA-256 datapath memory interfaces.
//   WORD_WIDTH      : bits per digest word
//   NUM_HASH_WORDS  : words per SHA-256 digest (H0..H7)
//   writer_state_t  : digest writer FSM states
//   word_offset()   : bit offset of a word inside a packed digest whose
//                     word 0 sits in the most significant bits
package sha256_pkg;

    localparam int WORD_WIDTH     = 32;
    localparam int NUM_HASH_WORDS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } writer_state_t;

    // Word 0 is the most significant word, so word i starts
    // (num_words-1-i) words up from bit 0.
    function automatic int unsigned word_offset(
        input int unsigned index,
        input int unsigned num_words,
        input int unsigned width
    );
        return (num_words - 1 - index) * width;
    endfunction

endpackage

// File: rtl/sha256_digest_writer_counter.sv
// write_address_counter
// Word index counter for the digest writer, the write-side twin of the
// block-read address counter.
// Ports:
//   clock, reset (synchronous, active-high)
//   clear      : force the index back to 0
//   increment  : advance the index by one
//   index      : current word index
//   last_word  : index points at the final word (COUNT-1)
module write_address_counter
    import sha256_pkg::*;
#(
    parameter int COUNT = NUM_HASH_WORDS
)(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     increment,
    output logic [$clog2(COUNT)-1:0] index,
    output logic                     last_word
);

    localparam int INDEX_WIDTH = $clog2(COUNT);

    // Clear has priority so a transfer that ends on the last word always
    // leaves the counter at 0 for the next digest.
    always_ff @(posedge clock) begin
        if (reset) begin
            index <= '0;
        end else if (clear) begin
            index <= '0;
        end else if (increment) begin
            index <= index + INDEX_WIDTH'(1);
        end
    end

    assign last_word = (index == INDEX_WIDTH'(COUNT - 1));

endmodule

// File: rtl/sha256_digest_writer.sv
// sha256_digest_writer
// Captures a finished SHA-256 digest and streams its words to the output
// SRAM one per cycle at consecutive addresses starting at BASE_ADDRESS,
// then pulses write_complete.
// Ports:
//   clock, reset       : clock, synchronous active-high reset
//   hash_valid         : one-cycle strobe, hash_in holds a finished digest
//   hash_in            : packed digest, word 0 (H0) in the top bits
//   mem_ready          : (SHA_WRITER_STALL_EN only) SRAM accepts the write
//   busy               : captured digest not yet fully written
//   write_enable       : SRAM write strobe
//   write_address      : SRAM address
//   write_data         : SRAM write data
//   write_complete     : one-cycle pulse after the last word is written
// Build option: define SHA_WRITER_STALL_EN to add mem_ready back-pressure.
module sha256_digest_writer
    import sha256_pkg::*;
#(
    parameter int                    NUMBER_OF_WORDS = NUM_HASH_WORDS,
    parameter int                    DATA_WIDTH      = WORD_WIDTH,
    parameter int                    ADDR_WIDTH      = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS    = '0
)(
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  hash_valid,
    input  logic [NUMBER_OF_WORDS*DATA_WIDTH-1:0] hash_in,
`ifdef SHA_WRITER_STALL_EN
    input  logic                                  mem_ready,
`endif
    output logic                                  busy,
    output logic                                  write_enable,
    output logic [ADDR_WIDTH-1:0]                 write_address,
    output logic [DATA_WIDTH-1:0]                 write_data,
    output logic                                  write_complete
);

    localparam int INDEX_WIDTH = $clog2(NUMBER_OF_WORDS);

    writer_state_t                         state;
    logic [NUMBER_OF_WORDS*DATA_WIDTH-1:0] digest_hold;
    logic [INDEX_WIDTH-1:0]                word_index;
    logic                                  last_word;
    logic                                  advance;
    logic                                  count_clear;
    logic                                  count_increment;

    // The presented word may be replaced only once the SRAM has taken it;
    // with nothing presented (write_enable low) the first word goes out
    // immediately.
`ifdef SHA_WRITER_STALL_EN
    assign advance = !write_enable || mem_ready;
`else
    assign advance = 1'b1;
`endif

    // The index always names the next word to present, so it steps as
    // each word is put on the bus and clears when the last one goes out.
    assign count_increment = (state == WRITE) && advance && !last_word;
    assign count_clear     = (state == WRITE) && advance && last_word;

    write_address_counter #(
        .COUNT (NUMBER_OF_WORDS)
    ) u_counter (
        .clock     (clock),
        .reset     (reset),
        .clear     (count_clear),
        .increment (count_increment),
        .index     (word_index),
        .last_word (last_word)
    );

    // State and all outputs live in one block. The state leads the
    // registered outputs by one cycle: WRITE is entered on capture and the
    // first word appears on the next edge; DONE is entered as the last word
    // is presented and write_complete appears once that word is taken.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            digest_hold    <= '0;
            busy           <= 1'b0;
            write_enable   <= 1'b0;
            write_address  <= '0;
            write_data     <= '0;
            write_complete <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    busy           <= 1'b0;
                    write_enable   <= 1'b0;
                    write_complete <= 1'b0;
                    if (hash_valid) begin
                        digest_hold <= hash_in;
                        state       <= WRITE;
                    end
                end
                WRITE: begin
                    busy           <= 1'b1;
                    write_complete <= 1'b0;
                    if (advance) begin
                        write_enable  <= 1'b1;
                        write_address <= BASE_ADDRESS + ADDR_WIDTH'(word_index);
                        write_data    <= DATA_WIDTH'(digest_hold >>
                                         word_offset(32'(word_index),
                                                     NUMBER_OF_WORDS,
                                                     DATA_WIDTH));
                        if (last_word) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (advance) begin
                        write_enable   <= 1'b0;
                        write_complete <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_digest_writer.sv
// tb_sha256_digest_writer
// Directed bench for sha256_digest_writer: reset state, a full transfer
// with an ignored mid-transfer strobe, address wrap-around via a second
// instance at BASE_ADDRESS 16'hFFFE, reset abort and recovery, and (when
// SHA_WRITER_STALL_EN is defined) a three-cycle stall on word 2.
module tb_sha256_digest_writer;

    logic         clock = 1'b0;
    logic         reset;
    logic         hash_valid;
    logic [255:0] hash_in;
    logic         mem_ready;

    logic         busy, write_enable, write_complete;
    logic [15:0]  write_address;
    logic [31:0]  write_data;

    logic         wrap_busy, wrap_write_enable, wrap_write_complete;
    logic [15:0]  wrap_write_address;
    logic [31:0]  wrap_write_data;

    int total_checks = 0;
    int bad_checks   = 0;

    logic [31:0] digest_a [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                  32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    logic [31:0] digest_b [8] = '{32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'hcafef00d,
                                  32'h0badc0de, 32'hfeedface, 32'h13579bdf, 32'h2468ace0};
    logic [31:0] junk     [8] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                                  32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
    logic [15:0] wrap_addr [8] = '{16'hfffe, 16'hffff, 16'h0000, 16'h0001,
                                   16'h0002, 16'h0003, 16'h0004, 16'h0005};

    always #5 clock = ~clock;

    sha256_digest_writer dut (
        .clock          (clock),
        .reset          (reset),
        .hash_valid     (hash_valid),
        .hash_in        (hash_in),
`ifdef SHA_WRITER_STALL_EN
        .mem_ready      (mem_ready),
`endif
        .busy           (busy),
        .write_enable   (write_enable),
        .write_address  (write_address),
        .write_data     (write_data),
        .write_complete (write_complete)
    );

    sha256_digest_writer #(
        .BASE_ADDRESS (16'hfffe)
    ) dut_wrap (
        .clock          (clock),
        .reset          (reset),
        .hash_valid     (hash_valid),
        .hash_in        (hash_in),
`ifdef SHA_WRITER_STALL_EN
        .mem_ready      (mem_ready),
`endif
        .busy           (wrap_busy),
        .write_enable   (wrap_write_enable),
        .write_address  (wrap_write_address),
        .write_data     (wrap_write_data),
        .write_complete (wrap_write_complete)
    );

    function automatic logic [255:0] pack_digest(input logic [31:0] w [8]);
        return {w[0], w[1], w[2], w[3], w[4], w[5], w[6], w[7]};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic step_edge();
        @(posedge clock);
        #1;
    endtask

    // Presents a digest for exactly one sampling edge (edge N).
    task automatic applyStimulus(input logic [255:0] digest);
        hash_valid = 1'b1;
        hash_in    = digest;
        step_edge();
        hash_valid = 1'b0;
    endtask

    // Full unstalled transfer; inject_at names the cycle whose edge sees a
    // stray hash_valid carrying junk (0 for none).
    task automatic run_transfer(input logic [31:0] words [8], input int inject_at);
        applyStimulus(pack_digest(words));
        for (int k = 1; k <= 8; k++) begin
            if (k == inject_at) begin
                hash_valid = 1'b1;
                hash_in    = pack_digest(junk);
            end
            step_edge();
            hash_valid = 1'b0;
            checkOutput($sformatf("we[%0d]", k),        write_enable, 1);
            checkOutput($sformatf("addr[%0d]", k),      write_address, 64'(k - 1));
            checkOutput($sformatf("data[%0d]", k),      write_data, words[k-1]);
            checkOutput($sformatf("busy[%0d]", k),      busy, 1);
            checkOutput($sformatf("complete[%0d]", k),  write_complete, 0);
            checkOutput($sformatf("wrap_addr[%0d]", k), wrap_write_address, wrap_addr[k-1]);
            checkOutput($sformatf("wrap_data[%0d]", k), wrap_write_data, words[k-1]);
        end
        step_edge();
        checkOutput("done_we",            write_enable, 0);
        checkOutput("done_complete",      write_complete, 1);
        checkOutput("done_busy",          busy, 1);
        checkOutput("wrap_done_complete", wrap_write_complete, 1);
        step_edge();
        checkOutput("idle_complete",      write_complete, 0);
        checkOutput("idle_busy",          busy, 0);
        checkOutput("wrap_idle_busy",     wrap_busy, 0);
    endtask

    task automatic run_abort();
        applyStimulus(pack_digest(digest_b));
        repeat (4) step_edge();
        checkOutput("abort_pre_addr", write_address, 3);
        checkOutput("abort_pre_data", write_data, digest_b[3]);
        reset = 1'b1;
        step_edge();
        reset = 1'b0;
        checkOutput("abort_we",   write_enable, 0);
        checkOutput("abort_busy", busy, 0);
        for (int k = 0; k < 12; k++) begin
            step_edge();
            checkOutput($sformatf("abort_quiet_we[%0d]", k),       write_enable, 0);
            checkOutput($sformatf("abort_quiet_complete[%0d]", k), write_complete, 0);
        end
    endtask

`ifdef SHA_WRITER_STALL_EN
    task automatic run_stall();
        logic [2:0] stall_addr [11] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2,
                                        3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        applyStimulus(pack_digest(digest_a));
        for (int k = 1; k <= 11; k++) begin
            step_edge();
            checkOutput($sformatf("stall_we[%0d]", k),       write_enable, 1);
            checkOutput($sformatf("stall_addr[%0d]", k),     write_address, 64'(stall_addr[k-1]));
            checkOutput($sformatf("stall_data[%0d]", k),     write_data, digest_a[stall_addr[k-1]]);
            checkOutput($sformatf("stall_complete[%0d]", k), write_complete, 0);
            if (k == 3) mem_ready = 1'b0;
            if (k == 6) mem_ready = 1'b1;
        end
        step_edge();
        checkOutput("stall_done_complete", write_complete, 1);
        checkOutput("stall_done_we",       write_enable, 0);
        step_edge();
        checkOutput("stall_idle_busy",     busy, 0);
    endtask
`endif

    initial begin
        reset      = 1'b1;
        hash_valid = 1'b0;
        hash_in    = '0;
        mem_ready  = 1'b1;
        repeat (3) step_edge();
        checkOutput("reset_busy",     busy, 0);
        checkOutput("reset_we",       write_enable, 0);
        checkOutput("reset_addr",     write_address, 0);
        checkOutput("reset_data",     write_data, 0);
        checkOutput("reset_complete", write_complete, 0);
        reset = 1'b0;
        step_edge();
        checkOutput("post_reset_busy", busy, 0);
        checkOutput("post_reset_we",   write_enable, 0);

        run_transfer(digest_a, 3);
        run_abort();
        run_transfer(digest_b, 0);
`ifdef SHA_WRITER_STALL_EN
        run_stall();
`endif

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
